// File: rtl/frustum_param_sequencer_if.sv
// Shared cos/sin lookup bus between the frustum sequencer (master) and the
// cos_sin_lookup block (slave). The master presents an angle request. The
// slave returns |cos|, |sin| (8 fractional bits) and their signs. The result
// for a request held during cycle k is valid during cycle k+1. There is no
// valid/ready handshake: the latency is fixed and known to both sides.
interface frustum_param_sequencer_if;
    logic [15:0] lut_angle_out;
    logic [15:0] lut_cos_abs_in;
    logic [15:0] lut_sin_abs_in;
    logic        lut_cos_sign_in;
    logic        lut_sin_sign_in;

    modport master (
        output lut_angle_out,
        input  lut_cos_abs_in,
        input  lut_sin_abs_in,
        input  lut_cos_sign_in,
        input  lut_sin_sign_in
    );

    modport slave (
        input  lut_angle_out,
        output lut_cos_abs_in,
        output lut_sin_abs_in,
        output lut_cos_sign_in,
        output lut_sin_sign_in
    );
endinterface

// File: rtl/frustum_param_sequencer.sv
// Per-frame camera/frustum parameter sequencer.
//
// When frame_start_in is accepted, the block latches the ball pose. It then
// looks up cos/sin for the heading and for both frustum edge angles through
// one shared LUT port. Next it evaluates cam_x, cam_y and the eight corner
// coordinates with a single time-multiplexed 16x16 multiplier. The results
// go into shadow registers and are committed to the outputs in one step.
// Cycle map (cycle 0 = frame_start_in sampled):
//   1      LATCH   request a, derive la/ra
//   2..5   LUT     request la, ra; capture a/la/ra results in 2/3/4
//   6..15  MUL     cam_x, cam_y, farl, farr, nearl, nearr (x before y)
//   16     COMMIT  params_valid_out high, committed outputs visible
//
// Optional build macro: FRUSTUM_ANGLE_WRAP_EN.
// When it is defined, angle_in is reduced mod 360 at capture.
module frustum_param_sequencer #(
    parameter int unsigned BALL_DEPTH = 7,
    parameter int unsigned HALF_FOV   = 55,
    parameter int unsigned NEAR_MAG   = 5,
    parameter int unsigned FAR_MAG    = 110,
    parameter int unsigned POS_OFFSET = 720
) (
    input  logic                             pixel_clk_in,
    input  logic                             rst_in,
    input  logic                             frame_start_in,
    input  logic [15:0]                      ballx_in,
    input  logic [15:0]                      bally_in,
    input  logic [15:0]                      angle_in,
    frustum_param_sequencer_if.master        lut,
    output logic [15:0]                      cam_x_out,
    output logic [15:0]                      cam_y_out,
    output logic [127:0]                     corners_out,
    output logic                             params_valid_out,
    output logic                             busy_out,
    output logic                             overrun_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_LUT,
        S_MUL,
        S_COMMIT
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [15:0] bx_q, by_q, a_q;
    logic [15:0] lut_angle_q;
    // Index 0 = heading a, 1 = left edge la, 2 = right edge ra.
    logic [15:0] cos_q [0:2];
    logic [15:0] sin_q [0:2];
    logic [2:0]  cos_neg_q, sin_neg_q;
    logic [15:0] cam_x_sh_q, cam_y_sh_q;
    logic [15:0] corner_sh_q [0:7];
    logic [15:0] cam_x_q, cam_y_q;
    logic [127:0] corners_q;
    logic        pv_q, ov_q;

    logic [15:0] a_cap_d, bx_cap_d, by_cap_d;
    logic [15:0] la_d, ra_d;
    logic [16:0] la_sum, ra_sum;
    logic [15:0] mul_mag_d, mul_abs_d, mul_base_d, mul_term_d, mul_res_d;
    logic        mul_neg_d, mul_sh8_d;
    logic [31:0] mul_prod_d;
    logic [4:0]  cnt_off;
    logic [2:0]  corner_idx_d;
    logic [1:0]  lsel_d;
    logic [127:0] corners_d;
    logic        unused_bits;

    // Pose capture: integer part of the 11.5 position plus the map offset.
    always_comb begin
        bx_cap_d = {5'd0, ballx_in[15:5]} + 16'(POS_OFFSET);
        by_cap_d = {5'd0, bally_in[15:5]} + 16'(POS_OFFSET);
`ifdef FRUSTUM_ANGLE_WRAP_EN
        a_cap_d  = angle_in % 16'd360;
`else
        a_cap_d  = angle_in;
`endif
    end

    // Frustum edge angles. Adding 360 before subtracting keeps ra non-negative.
    always_comb begin
        la_sum = {1'b0, a_q} + 17'(HALF_FOV);
        ra_sum = {1'b0, a_q} + 17'(360 - HALF_FOV);
        la_d   = (la_sum >= 17'd360) ? 16'(la_sum - 17'd360) : la_sum[15:0];
        ra_d   = (ra_sum >= 17'd360) ? 16'(ra_sum - 17'd360) : ra_sum[15:0];
    end

    // Shared multiplier: select operands for this cycle, then shift and add/subtract.
    always_comb begin
        mul_mag_d    = 16'(BALL_DEPTH);
        mul_abs_d    = cos_q[0];
        mul_neg_d    = cos_neg_q[0];
        mul_base_d   = bx_q;
        mul_sh8_d    = 1'b1;
        cnt_off      = cnt_q - 5'd8;
        corner_idx_d = cnt_off[2:0];
        lsel_d       = corner_idx_d[1] ? 2'd2 : 2'd1;
        case (cnt_q)
            5'd6: begin
                // cam_x = bx + term when cos is positive.
                mul_neg_d = cos_neg_q[0];
            end
            5'd7: begin
                // cam_y = by - term when sin is positive.
                mul_abs_d  = sin_q[0];
                mul_neg_d  = ~sin_neg_q[0];
                mul_base_d = by_q;
            end
            default: begin
                mul_sh8_d = 1'b0;
                mul_mag_d = corner_idx_d[2] ? 16'(NEAR_MAG) : 16'(FAR_MAG);
                if (corner_idx_d[0]) begin
                    mul_abs_d  = sin_q[lsel_d];
                    mul_neg_d  = sin_neg_q[lsel_d];
                    mul_base_d = cam_y_sh_q;
                end else begin
                    mul_abs_d  = cos_q[lsel_d];
                    mul_neg_d  = ~cos_neg_q[lsel_d];
                    mul_base_d = cam_x_sh_q;
                end
            end
        endcase
        mul_prod_d = {16'd0, mul_mag_d} * {16'd0, mul_abs_d};
        mul_term_d = mul_sh8_d ? mul_prod_d[23:8] : mul_prod_d[20:5];
        mul_res_d  = mul_neg_d ? (mul_base_d - mul_term_d) : (mul_base_d + mul_term_d);
    end

    // Commit image: shadow corners, with the final nearr_y forwarded from the multiplier.
    always_comb begin
        corners_d = '0;
        for (int i = 0; i < 8; i++) begin
            corners_d[127 - 16*i -: 16] = (i == 7) ? mul_res_d : corner_sh_q[i];
        end
    end

    assign unused_bits = ^{ballx_in[4:0], bally_in[4:0], mul_prod_d[31:24],
                           mul_prod_d[4:0], cnt_off[4:3]};

    // Sequencer FSM with registered outputs and shadow/commit registers.
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bx_q        <= '0;
            by_q        <= '0;
            a_q         <= '0;
            lut_angle_q <= '0;
            for (int i = 0; i < 3; i++) begin
                cos_q[i] <= '0;
                sin_q[i] <= '0;
            end
            cos_neg_q   <= '0;
            sin_neg_q   <= '0;
            cam_x_sh_q  <= '0;
            cam_y_sh_q  <= '0;
            for (int i = 0; i < 8; i++) begin
                corner_sh_q[i] <= '0;
            end
            cam_x_q     <= '0;
            cam_y_q     <= '0;
            corners_q   <= '0;
            pv_q        <= 1'b0;
            ov_q        <= 1'b0;
        end else begin
            pv_q <= 1'b0;
            ov_q <= frame_start_in && (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (frame_start_in) begin
                        bx_q        <= bx_cap_d;
                        by_q        <= by_cap_d;
                        a_q         <= a_cap_d;
                        lut_angle_q <= a_cap_d;
                        cnt_q       <= 5'd1;
                        state_q     <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    lut_angle_q <= la_d;
                    cnt_q       <= cnt_q + 5'd1;
                    state_q     <= S_LUT;
                end
                S_LUT: begin
                    cnt_q <= cnt_q + 5'd1;
                    case (cnt_q)
                        5'd2: begin
                            lut_angle_q  <= ra_d;
                            cos_q[0]     <= lut.lut_cos_abs_in;
                            sin_q[0]     <= lut.lut_sin_abs_in;
                            cos_neg_q[0] <= lut.lut_cos_sign_in;
                            sin_neg_q[0] <= lut.lut_sin_sign_in;
                        end
                        5'd3: begin
                            cos_q[1]     <= lut.lut_cos_abs_in;
                            sin_q[1]     <= lut.lut_sin_abs_in;
                            cos_neg_q[1] <= lut.lut_cos_sign_in;
                            sin_neg_q[1] <= lut.lut_sin_sign_in;
                        end
                        5'd4: begin
                            cos_q[2]     <= lut.lut_cos_abs_in;
                            sin_q[2]     <= lut.lut_sin_abs_in;
                            cos_neg_q[2] <= lut.lut_cos_sign_in;
                            sin_neg_q[2] <= lut.lut_sin_sign_in;
                        end
                        default: begin
                            // Settle cycle before the multiplier phase.
                            state_q <= S_MUL;
                        end
                    endcase
                end
                S_MUL: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd6) begin
                        cam_x_sh_q <= mul_res_d;
                    end else if (cnt_q == 5'd7) begin
                        cam_y_sh_q <= mul_res_d;
                    end else begin
                        corner_sh_q[corner_idx_d] <= mul_res_d;
                    end
                    if (cnt_q == 5'd15) begin
                        cam_x_q   <= cam_x_sh_q;
                        cam_y_q   <= cam_y_sh_q;
                        corners_q <= corners_d;
                        pv_q      <= 1'b1;
                        state_q   <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign lut.lut_angle_out = lut_angle_q;
    assign cam_x_out         = cam_x_q;
    assign cam_y_out         = cam_y_q;
    assign corners_out       = corners_q;
    assign params_valid_out  = pv_q;
    assign overrun_out       = ov_q;
    assign busy_out          = (state_q != S_IDLE);

endmodule
